therm2bin_dec: RTL and testbench

Pipelined thermometer-to-binary decoder: accepts a 31-bit thermometer code through a valid/ready handshake and returns the 5-bit binary count two cycles later. It is the inverse of the bin2therm converter. It sits on the return path of the thermometer-coded fractional-divider and DAC control chain, where decoded codes are read back for monitoring and calibration. Decoding is by population count, so single bubbles still yield a best-effort value. Optional checking flags and counts malformed codes.

---
 rtl/therm_pkg.sv | 26 ++
 rtl/therm_popcnt.sv | 25 ++
 rtl/therm2bin_dec.sv | 159 +++++++++++++++
 tb/tb_therm2bin_dec.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/therm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : therm_pkg
//  Description : Shared definitions for the thermometer-code converters
//                (bin2therm and therm2bin). Holds the default binary width,
//                the derived thermometer width and the legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package therm_pkg;

    localparam int W_BIN_DEFAULT   = 5;
    localparam int N_THERM_DEFAULT = (2 ** W_BIN_DEFAULT) - 1;

    typedef logic [N_THERM_DEFAULT-1:0] therm_t;

    // A legal thermometer code is a contiguous run of ones starting at bit 0,
    // so adding one carries through the whole run and clears every set bit.
    // All-zeros and all-ones both satisfy this.
    function automatic logic is_therm(input therm_t code);
        therm_t code_p1;
        code_p1 = code + therm_t'(1);
        return ((code & code_p1) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/therm_popcnt.sv
`default_nettype none
// ============================================================================
//  Module      : therm_popcnt
//  Description : Combinational population count of a WIDTH-bit vector.
//                Used for each half of the thermometer decoder's first stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module therm_popcnt #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CNT_W-1:0] count
);

    // Sum every input bit; the count width holds the all-ones case exactly.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/therm2bin_dec.sv
`default_nettype none
// ============================================================================
//  Module      : therm2bin_dec
//  Description : Two-stage pipelined thermometer-to-binary decoder with
//                valid/ready handshakes on both sides. Decodes by population
//                count so bubbled codes still give a best-effort value.
//                Optional bubble checking (out_err / err_cnt / err_clr) is
//                built only when THERM2BIN_BUBBLE_CHK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module therm2bin_dec
    import therm_pkg::*;
#(
    parameter  int W_BIN     = W_BIN_DEFAULT,
    parameter  int ERR_CNT_W = 8,
    localparam int N_THERM   = (2 ** W_BIN) - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_THERM-1:0]   in_therm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W_BIN-1:0]     out_bin,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Lower half is one bit wider than the upper half (16 + 15 for 31 bits).
    localparam int LO_W  = 2 ** (W_BIN - 1);
    localparam int HI_W  = N_THERM - LO_W;
    localparam int LO_CW = $clog2(LO_W + 1);
    localparam int HI_CW = $clog2(HI_W + 1);

    // ------------------------------------------------------------------------
    // Handshake / stall control
    // ------------------------------------------------------------------------
    logic s1_valid;
    logic s2_adv;
    logic s1_adv;

    // S2 may load whenever it is empty or its content leaves this cycle; S1
    // may load whenever it is empty or S2 takes its content. in_ready is
    // therefore combinational from out_ready, allowing full throughput.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ------------------------------------------------------------------------
    // Stage 1: half-width population counts
    // ------------------------------------------------------------------------
    logic [LO_CW-1:0] lo_cnt;
    logic [HI_CW-1:0] hi_cnt;
    logic [LO_CW-1:0] s1_lo_cnt;
    logic [HI_CW-1:0] s1_hi_cnt;

    therm_popcnt #(
        .WIDTH (LO_W)
    ) u_popcnt_lo (
        .bits  (in_therm[LO_W-1:0]),
        .count (lo_cnt)
    );

    therm_popcnt #(
        .WIDTH (HI_W)
    ) u_popcnt_hi (
        .bits  (in_therm[N_THERM-1:LO_W]),
        .count (hi_cnt)
    );

    // Data path: capture half counts in S1, then their sum in S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_lo_cnt <= '0;
            s1_hi_cnt <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_lo_cnt <= lo_cnt;
                    s1_hi_cnt <= hi_cnt;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    // Sum is at most N_THERM, which always fits in W_BIN bits.
                    out_bin <= W_BIN'(s1_lo_cnt) + W_BIN'(s1_hi_cnt);
                end
            end
        end
    end

`ifdef THERM2BIN_BUBBLE_CHK_EN
    // ------------------------------------------------------------------------
    // Bubble checking
    // ------------------------------------------------------------------------
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic legal_d;
    logic s1_legal;
    logic err_inc;

    // The shared package function covers the default width; other widths use
    // the same carry-through test sized to the actual input.
    generate
        if (N_THERM == N_THERM_DEFAULT) begin : g_pkg_chk
            assign legal_d = is_therm(therm_t'(in_therm));
        end else begin : g_gen_chk
            logic [N_THERM-1:0] therm_p1;
            assign therm_p1 = in_therm + N_THERM'(1);
            assign legal_d  = ((in_therm & therm_p1) == '0);
        end
    endgenerate

    // Legality flag travels alongside the data with the same advance rules.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_legal <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            if (s1_adv && in_valid) begin
                s1_legal <= legal_d;
            end
            if (s2_adv && s1_valid) begin
                out_err <= !s1_legal;
            end
        end
    end

    // Count only delivered illegal codes, not ones still waiting in S2.
    assign err_inc = out_valid && out_ready && out_err;

    // Saturating error counter; a clear overrides a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err_inc && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`else
    // Checking not built: error outputs are constant and err_clr has no effect.
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign out_err        = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_therm2bin_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_therm2bin_dec
//  Description : Self-checking bench for therm2bin_dec. Directed vectors with
//                hand-computed results plus a randomised stream checked
//                against a popcount model; works with or without
//                THERM2BIN_BUBBLE_CHK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_therm2bin_dec;

    localparam int W_BIN     = 5;
    localparam int N_THERM   = 31;
    localparam int ERR_CNT_W = 8;

`ifdef THERM2BIN_BUBBLE_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [N_THERM-1:0]   in_therm;
    logic                 out_valid;
    logic                 out_ready;
    logic [W_BIN-1:0]     out_bin;
    logic                 out_err;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_cnt;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_delivered = 0;
    int         stall_cycles = 0;
    logic [5:0] exp_q[$];          // {expected err, expected bin}
    logic [5:0] mon_e;
    logic       rand_on = 1'b0;
    logic [30:0] tb_code;
    int         tb_k;
    int         tb_cnt;
    logic       tb_legal;

    therm2bin_dec #(
        .W_BIN     (W_BIN),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_therm  (in_therm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one code; record its expected result when it is accepted.
    // Entered and left 1 time unit after a rising edge.
    task automatic send(input logic [30:0] code, input logic [4:0] eb, input logic ee);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_therm = code;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            stall_cycles++;
            guard++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        else           exp_q.push_back({ee & CHK_EN, eb});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_therm = '0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 400) begin
            guard++;
            @(negedge clk);
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every delivered result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_bin", out_bin, mon_e[4:0]);
                check("out_err", out_err, mon_e[5]);
                n_delivered++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_therm  = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_bin", out_bin, 32'd0);
        check("rst_out_err", out_err, 32'd0);
        check("rst_err_cnt", err_cnt, 32'd0);
        @(posedge clk);
        #1;

        // All 32 legal codes back to back; k ones decodes to k
        n_delivered  = 0;
        stall_cycles = 0;
        for (int k = 0; k < 32; k++) begin
            tb_code = (k == 31) ? 31'h7FFF_FFFF : 31'((32'd1 << k) - 32'd1);
            send(tb_code, 5'(k), 1'b0);
        end
        drain();
        check("seq_count", n_delivered, 32'd32);
        check("seq_no_stall", stall_cycles, 32'd0);
        check("seq_err_cnt", err_cnt, 32'd0);

        // Single bubble 0b101: two ones, illegal; also pins the latency
        send(31'h0000_0005, 5'd2, 1'b1);
        @(negedge clk);
        check("lat_stage1_valid", out_valid, 32'd0);
        @(negedge clk);
        check("lat_stage2_valid", out_valid, 32'd1);
        check("bubble_bin", out_bin, 32'd2);
        check("bubble_err", out_err, CHK_EN ? 32'd1 : 32'd0);
        @(negedge clk);
        check("bubble_err_cnt", err_cnt, CHK_EN ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;

        // Stall: fill both stages with out_ready low, hold, then release
        out_ready   = 1'b0;
        n_delivered = 0;
        send(31'h0000_0007, 5'd3, 1'b0);
        send(31'h0000_001F, 5'd5, 1'b0);
        fork
            begin
                send(31'h0000_00FF, 5'd8, 1'b0);
                send(31'h0000_0000, 5'd0, 1'b0);
                send(31'h0000_7FFF, 5'd15, 1'b0);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 32'd0);
                    check("stall_hold_valid", out_valid, 32'd1);
                    check("stall_hold_bin", out_bin, 32'd3);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", n_delivered, 32'd5);

        // Saturation with 300 illegal codes 0b10 (one one)
        for (int i = 0; i < 300; i++) begin
            send(31'h0000_0002, 5'd1, 1'b1);
        end
        drain();
        check("sat_err_cnt", err_cnt, CHK_EN ? 32'd255 : 32'd0);
        // Clear coincident with another illegal transfer
        send(31'h0000_0002, 5'd1, 1'b1);
        @(posedge clk);
        #1;
        check("clr_coincident_valid", out_valid, 32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_err_cnt", err_cnt, 32'd0);
        send(31'h0000_0002, 5'd1, 1'b1);
        drain();
        check("post_clr_err_cnt", err_cnt, CHK_EN ? 32'd1 : 32'd0);

        // Asynchronous reset with two codes in flight
        out_ready = 1'b0;
        send(31'h0000_0007, 5'd3, 1'b0);
        send(31'h0000_003F, 5'd6, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("rst_async_out_valid", out_valid, 32'd0);
        check("rst_async_err_cnt", err_cnt, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        out_ready   = 1'b1;
        n_delivered = 0;
        send(31'h7FFF_FFFF, 5'd31, 1'b0);
        drain();
        check("rst_after_count", n_delivered, 32'd1);

        // Random codes with random gaps and backpressure
        n_delivered = 0;
        rand_on     = 1'b1;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        tb_k    = $urandom_range(0, 31);
                        tb_code = (tb_k == 31) ? 31'h7FFF_FFFF : 31'((32'd1 << tb_k) - 32'd1);
                    end else begin
                        tb_code = 31'($urandom);
                    end
                    tb_cnt   = $countones(tb_code);
                    tb_legal = ({1'b0, tb_code} == ((32'd1 << tb_cnt) - 32'd1));
                    send(tb_code, 5'(tb_cnt), !tb_legal);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_count", n_delivered, 32'd150);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
